// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encodings and default width.
package countdown_timer_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_core.sv
// Count register of the countdown timer: load, reload, force-to-zero and decrement muxing.
// Priority: load > reload > to_zero > dec > hold.
module countdown_core #(
    parameter int WIDTH = countdown_timer_pkg::DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             reload,
    input  logic             to_zero,
    input  logic             dec,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;

    always_comb begin
        q_d      = q_q;
        reload_d = reload_q;
        if (load) begin
            q_d      = load_value;
            reload_d = load_value;
        end else if (reload) begin
            q_d = reload_q;
        end else if (to_zero) begin
            q_d = '0;
        end else if (dec) begin
            q_d = q_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q_q      <= '0;
            reload_q <= '0;
        end else begin
            q_q      <= q_d;
            reload_q <= reload_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down counter with one-cycle done pulse, one-shot or periodic reload.
// Optional COUNTDOWN_OVERRUN_EN adds ack input and sticky overrun output.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             reload_mode,
`ifdef COUNTDOWN_OVERRUN_EN
    input  logic             ack,
    output logic             overrun,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             zero,
    output logic             done
);

    state_t state_q, state_d;
    logic   done_q, done_d;
    logic   core_reload, core_to_zero, core_dec;

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        core_reload  = 1'b0;
        core_to_zero = 1'b0;
        core_dec     = 1'b0;
        // Load wins over a terminal count in the same cycle.
        if (load) begin
            if (load_value != '0) begin
                state_d = RUN;
            end else begin
                state_d = EXPIRED;
                done_d  = 1'b1;
            end
        end else if (state_q == RUN && enable) begin
            if (q == WIDTH'(1)) begin
                done_d = 1'b1;
                if (reload_mode) begin
                    core_reload = 1'b1;
                end else begin
                    core_to_zero = 1'b1;
                    state_d      = EXPIRED;
                end
            end else begin
                core_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    countdown_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clock      (clock),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .reload     (core_reload),
        .to_zero    (core_to_zero),
        .dec        (core_dec),
        .q          (q)
    );

    assign busy = (state_q == RUN);
    assign zero = (q == '0);
    assign done = done_q;

`ifdef COUNTDOWN_OVERRUN_EN
    logic pending_q, pending_d;
    logic overrun_q, overrun_d;

    // A visible done pulse sets pending even when ack arrives in the same cycle.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (done_q) begin
            pending_d = 1'b1;
            if (pending_q && !ack) begin
                overrun_d = 1'b1;
            end
        end else if (ack) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus pushes expected outputs, monitor pops and compares.
module tb_countdown_timer;

    localparam int W = 3;

    logic         clock = 1'b0;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         enable = 1'b0;
    logic         reload_mode = 1'b0;
    logic [W-1:0] q;
    logic         busy, zero, done;
    logic         ack = 1'b0;
    logic         overrun;

    countdown_timer #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .reload_mode (reload_mode),
`ifdef COUNTDOWN_OVERRUN_EN
        .ack         (ack),
        .overrun     (overrun),
`endif
        .q           (q),
        .busy        (busy),
        .zero        (zero),
        .done        (done)
    );

`ifndef COUNTDOWN_OVERRUN_EN
    assign overrun = 1'b0;
`endif

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        logic         ov;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic exp_ov = 1'b0;

    // Monitor: outputs settle 1 time unit after any clock edge or clear assertion.
    always @(posedge clock or posedge clear) begin
        exp_t e;
        logic bad;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            bad = (q !== e.q) || (busy !== e.busy) || (done !== e.done) ||
                  (zero !== (e.q == '0));
`ifdef COUNTDOWN_OVERRUN_EN
            bad = bad || (overrun !== e.ov);
`endif
            if (bad) begin
                miscompares++;
                $display("FAIL %s: got q=%0d busy=%0b zero=%0b done=%0b ov=%0b, expected q=%0d busy=%0b zero=%0b done=%0b ov=%0b",
                         e.name, q, busy, zero, done, overrun,
                         e.q, e.busy, (e.q == '0), e.done, e.ov);
            end else begin
                $display("vec %0d %s: q=%0d busy=%0b done=%0b ok", vectors, e.name, q, busy, done);
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] eq, input logic eb, input logic ed, input string nm);
        exp_t e;
        e.q = eq; e.busy = eb; e.done = ed; e.ov = exp_ov; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic ld, input logic [W-1:0] lv, input logic en, input logic rm,
                        input logic [W-1:0] eq, input logic eb, input logic ed, input string nm);
        load = ld; load_value = lv; enable = en; reload_mode = rm;
        push_exp(eq, eb, ed, nm);
        @(posedge clock);
        #2;
    endtask

    // Asserted between edges; outputs are checked before the next clock edge.
    task automatic pulse_clear(input string nm);
        load = 1'b0; enable = 1'b0;
        exp_ov = 1'b0;
        push_exp('0, 1'b0, 1'b0, nm);
        clear = 1'b1;
        #3;
        clear = 1'b0;
        @(posedge clock);
        #2;
    endtask

    initial begin
        #1;
        push_exp('0, 1'b0, 1'b0, "reset");
        clear = 1'b1;
        #2;
        clear = 1'b0;
        @(posedge clock);
        #2;

        step(0, 0, 1, 0, 0, 0, 0, "idle_enable_ignored");

        step(1, 3, 0, 0, 3, 1, 0, "os_load3");
        step(0, 0, 1, 0, 2, 1, 0, "os_q2");
        step(0, 0, 1, 0, 1, 1, 0, "os_q1");
        step(0, 0, 1, 0, 0, 0, 1, "os_terminal");
        step(0, 0, 1, 0, 0, 0, 0, "os_expired_hold");
        step(0, 0, 1, 1, 0, 0, 0, "os_expired_hold_rm");

        step(1, 3, 0, 1, 3, 1, 0, "per_load3");
        for (int p = 0; p < 3; p++) begin
            step(0, 0, 1, 1, 2, 1, 0, "per_q2");
            step(0, 0, 1, 1, 1, 1, 0, "per_q1");
            step(0, 0, 1, 1, 3, 1, 1, "per_reload");
        end

        step(1, 5, 0, 0, 5, 1, 0, "gate_load5");
        step(0, 0, 1, 0, 4, 1, 0, "gate_en1");
        step(0, 0, 0, 0, 4, 1, 0, "gate_en0");
        step(0, 0, 1, 0, 3, 1, 0, "gate_en1b");
        step(0, 0, 0, 0, 3, 1, 0, "gate_en0b");

        step(0, 0, 1, 0, 2, 1, 0, "coll_q2");
        step(0, 0, 1, 0, 1, 1, 0, "coll_q1");
        step(1, 6, 1, 0, 6, 1, 0, "coll_load_wins");
        step(1, 0, 0, 0, 0, 0, 1, "load_zero_expired");
        step(0, 0, 1, 0, 0, 0, 0, "load_zero_after");

        step(1, 2, 0, 0, 2, 1, 0, "dl_load2");
        step(0, 0, 1, 0, 1, 1, 0, "dl_q1");
        step(0, 0, 1, 0, 0, 0, 1, "dl_terminal");
        step(1, 4, 0, 0, 4, 1, 0, "dl_reload_next");

        step(1, 5, 0, 0, 5, 1, 0, "clr_load5");
        pulse_clear("clear_mid_run");
        step(0, 0, 1, 0, 0, 0, 0, "clear_idle_hold");

`ifdef COUNTDOWN_OVERRUN_EN
        ack = 1'b0;
        step(1, 2, 0, 1, 2, 1, 0, "ov_load2");
        step(0, 0, 1, 1, 1, 1, 0, "ov_q1");
        step(0, 0, 1, 1, 2, 1, 1, "ov_done1");
        step(0, 0, 1, 1, 1, 1, 0, "ov_pending");
        step(0, 0, 1, 1, 2, 1, 1, "ov_done2");
        exp_ov = 1'b1;
        step(0, 0, 1, 1, 1, 1, 0, "ov_set");
        step(1, 2, 0, 1, 2, 1, 0, "ov_sticky_load");
        pulse_clear("ov_cleared");

        step(1, 2, 0, 1, 2, 1, 0, "ack_load2");
        step(0, 0, 1, 1, 1, 1, 0, "ack_q1");
        step(0, 0, 1, 1, 2, 1, 1, "ack_done1");
        for (int k = 0; k < 3; k++) begin
            ack = 1'b0;
            step(0, 0, 1, 1, 1, 1, 0, "ack_after_done");
            ack = 1'b1;
            step(0, 0, 1, 1, 2, 1, 1, "ack_cleared_done");
        end
        ack = 1'b0;
        step(0, 0, 1, 1, 1, 1, 0, "ack_no_overrun");
`endif

        load = 1'b0; enable = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable N-bit down counter with a terminal-count flag, a complement to the existing up-counter blocks in the lab library.
- Counts a loaded value down to zero, then raises a one-cycle done pulse. It either stops there (one-shot) or reloads and keeps counting (periodic).
- Used as a programmable delay or period generator beside the up counters, on the same clock/clear scheme.

Parameters:
- WIDTH, 3, counter width in bits; valid range 2..16.

Ports:
- clock  input  1  single system clock; all state changes on posedge.
- clear  input  1  asynchronous, active-high reset; forces all state to reset values immediately.
- load  input  1  synchronous load strobe; samples load_value.
- load_value  input  WIDTH  start and reload value.
- enable  input  1  count enable; decrement happens only when high.
- reload_mode  input  1  0 = one-shot, 1 = periodic reload; sampled each cycle.
- q  output  WIDTH  current count value (registered).
- busy  output  1  high while in RUN.
- zero  output  1  high whenever q == 0 (combinational from q).
- done  output  1  one-cycle pulse on terminal count (registered).

Behaviour:
- Reset (clear=1, asynchronous): q=0, state=IDLE, reload register=0, done=0, busy=0. Therefore zero=1.
- States: IDLE, RUN, EXPIRED (2-bit encoding, constants in shared header).
- Load (any state, load=1 at posedge):
  - q<=load_value and reload register<=load_value.
  - If load_value!=0, next state is RUN. If load_value==0, next state is EXPIRED with done=1 on that edge.
- RUN, enable=0: hold q; no done.
- RUN, enable=1, q>1: q<=q-1.
- RUN, enable=1, q==1:
  - reload_mode=0: q<=0, state<=EXPIRED, done<=1.
  - reload_mode=1: q<=reload register, state stays RUN, done<=1. Count 0 is never presented; the period is exactly the loaded value of enabled cycles.
- EXPIRED: q holds 0. enable is ignored. Only load or clear leaves this state.
- IDLE: q holds; enable ignored.
- Latency: done asserts on the same edge that q reaches its terminal transition and lasts exactly one cycle. A load on the following edge does not suppress it.
- Load vs terminal in the same cycle: load wins. q=load_value, no done pulse.
- Arithmetic: unsigned, modulo 2^WIDTH. Decrement never wraps below 0 because of the q==1 rule.
- clear asserted mid-count aborts immediately. No done pulse is generated on or after clear.

Optional Feature:
- Macro: COUNTDOWN_OVERRUN_EN.
- Defined:
  - Adds input ack (1 bit) and output overrun (1 bit).
  - Internal pending flag: set by done, cleared by ack.
  - If done fires while pending=1 and ack=0 in that cycle, overrun<=1 (sticky).
  - overrun clears only on clear. ack and done in the same cycle leave pending=1.
- Undefined: no ack/overrun ports, no pending logic. Core behaviour is identical.

Decomposition:
- Shared header countdown_defs.vh, include-guarded like the other lab headers. Contains:
  - state encodings IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2;
  - default WIDTH constant.
- One natural sub-module: countdown_core. Holds the WIDTH-bit q register with load/decrement/reload muxing and its own async clear.
- The top module holds the FSM, the done register and the optional overrun logic.

Test Plan:
- clear=1 mid-run with q=5 -> q=0, busy=0, done=0 immediately, before the next clock edge; zero=1.
- One-shot: load_value=3, load, then enable=1 -> q sequence 3,2,1,0. done high for exactly the edge where q becomes 0; state EXPIRED; further enables leave q=0.
- Periodic: load_value=3, reload_mode=1, enable=1 for 9 cycles -> q 3,2,1,3,2,1,3,2,1; done pulses every 3rd cycle (3 pulses); busy stays 1.
- Enable gating: load 5, enable toggled 1,0,1,0 -> q 5,4,4,3,3; no done.
- Collision: q=1, enable=1, load=1 with load_value=6 same cycle -> q=6, no done, state RUN. Also load_value=0 -> EXPIRED with done=1 that edge.
- COUNTDOWN_OVERRUN_EN: periodic load 2, ack held 0 -> second done sets overrun=1. Re-run with ack pulsed after each done -> overrun stays 0; overrun cleared only by clear.
